// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 set-2 prefix decoder feeding a key event FIFO
// Optional typematic repeat filter enabled by defining PS2_TYPEMATIC_FILTER_EN.
module ps2_key_decoder #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          ps2_key_pressed,
   input  logic [7:0]    ps2_key_data,
   input  logic          key_ack,
   output logic          key_valid,
   output logic [7:0]    key_code,
   output logic          key_release,
   output logic          key_extended,
   output logic [CW-1:0] fifo_count,
   output logic          overflow
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK
   } state_t;

   state_t        r_state;
   logic [9:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;

   logic          w_noise;
   logic          w_event;
   logic          w_ext;
   logic          w_rel;
   logic          w_pass;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;
   logic [9:0]    w_head;

   // Line/controller responses that never belong to a key sequence
   always_comb begin
      w_noise = 1'b0;
      case (ps2_key_data)
         8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'h00, 8'hFF: w_noise = 1'b1;
         default:                                  w_noise = 1'b0;
      endcase
   end

   assign w_event = ps2_key_pressed && !w_noise &&
                    (ps2_key_data != 8'hE0) && (ps2_key_data != 8'hF0);
   assign w_ext   = (r_state == S_EXT) || (r_state == S_EXT_BRK);
   assign w_rel   = (r_state == S_BRK) || (r_state == S_EXT_BRK);

   assign w_full  = (r_count == CW'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_pop   = key_ack && !w_empty;
   assign w_push  = w_pass && (!w_full || w_pop);

`ifdef PS2_TYPEMATIC_FILTER_EN
   logic       r_held;
   logic [8:0] r_held_key;
   logic       w_same_key;

   assign w_same_key = r_held && (r_held_key == {w_ext, ps2_key_data});
   assign w_pass     = w_event && !(w_same_key && !w_rel);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_held     <= 1'b0;
         r_held_key <= '0;
      end else if (w_pass) begin
         if (!w_rel) begin
            if (w_push) begin
               r_held     <= 1'b1;
               r_held_key <= {w_ext, ps2_key_data};
            end
         end else if (w_same_key) begin
            r_held <= 1'b0;
         end
      end
   end
`else
   assign w_pass = w_event;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else if (ps2_key_pressed && !w_noise) begin
         if (ps2_key_data == 8'hE0) begin
            r_state <= S_EXT;
         end else if (ps2_key_data == 8'hF0) begin
            case (r_state)
               S_IDLE:  r_state <= S_BRK;
               S_EXT:   r_state <= S_EXT_BRK;
               default: r_state <= r_state;
            endcase
         end else begin
            r_state <= S_IDLE;
         end
      end
   end

   // Storage carries no reset: an entry is only observable once r_count covers it
   always_ff @(posedge clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {w_ext, w_rel, ps2_key_data};
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_pass && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign w_head       = r_mem[r_rd_ptr];
   assign key_valid    = !w_empty;
   assign key_code     = w_empty ? 8'h00 : w_head[7:0];
   assign key_release  = !w_empty && w_head[8];
   assign key_extended = !w_empty && w_head[9];
   assign fifo_count   = r_count;
   assign overflow     = r_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - scoreboard bench for ps2_key_decoder
// Honours PS2_TYPEMATIC_FILTER_EN the same way as the design.
module tb_ps2_key_decoder;
   localparam int DEPTH = 4;
   localparam int CW    = 3;
`ifdef PS2_TYPEMATIC_FILTER_EN
   localparam int TYPEMATIC_EVENTS = 2;
`else
   localparam int TYPEMATIC_EVENTS = 4;
`endif

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          ps2_key_pressed = 1'b0;
   logic [7:0]    ps2_key_data = 8'h00;
   logic          key_ack = 1'b0;
   logic          key_valid;
   logic [7:0]    key_code;
   logic          key_release;
   logic          key_extended;
   logic [CW-1:0] fifo_count;
   logic          overflow;

   ps2_key_decoder #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clock           (clock),
      .resetn          (resetn),
      .ps2_key_pressed (ps2_key_pressed),
      .ps2_key_data    (ps2_key_data),
      .key_ack         (key_ack),
      .key_valid       (key_valid),
      .key_code        (key_code),
      .key_release     (key_release),
      .key_extended    (key_extended),
      .fifo_count      (fifo_count),
      .overflow        (overflow)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // expected events {extended, release, code}, oldest first
   logic [9:0] exp_q [$];

   int   m_count = 0;
   bit   m_ovf   = 0;
   bit   m_ext   = 0;
   bit   m_brk   = 0;
   bit   m_held  = 0;
   logic [8:0] m_held_key = '0;

   logic [7:0] pool [16] = '{8'hE0, 8'hF0, 8'hAA, 8'hFF, 8'h00, 8'h1C, 8'h1C, 8'h1C,
                             8'h32, 8'h75, 8'h15, 8'h6B, 8'hE0, 8'hF0, 8'h1C, 8'h22};

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic bit is_noise(logic [7:0] d);
      return d == 8'hAA || d == 8'hEE || d == 8'hFA || d == 8'hFE ||
             d == 8'h00 || d == 8'hFF;
   endfunction

   task automatic model_step(input logic stb, input logic [7:0] d, input logic ack);
      bit         pass;
      logic [9:0] e;
      pass = 0;
      e    = '0;
      if (ack && m_count > 0) m_count--;
      if (stb) begin
         if (d == 8'hE0) begin
            m_ext = 1;
            m_brk = 0;
         end else if (d == 8'hF0) begin
            m_brk = 1;
         end else if (!is_noise(d)) begin
            e     = {m_ext, m_brk, d};
            pass  = 1;
            m_ext = 0;
            m_brk = 0;
         end
      end
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (pass && m_held && m_held_key == {e[9], e[7:0]}) begin
         if (!e[8]) pass = 0;
         else       m_held = 0;
      end
`endif
      if (pass) begin
         if (m_count < DEPTH) begin
            m_count++;
            exp_q.push_back(e);
`ifdef PS2_TYPEMATIC_FILTER_EN
            if (!e[8]) begin
               m_held     = 1;
               m_held_key = {e[9], e[7:0]};
            end
`endif
         end else begin
            m_ovf = 1;
         end
      end
   endtask

   task automatic drive(input logic stb, input logic [7:0] d, input logic ack);
      @(posedge clock);
      #1;
      chk("fifo_count", 32'(fifo_count), 32'(m_count));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("key_valid", 32'(key_valid), 32'(m_count != 0));
      ps2_key_pressed = stb;
      ps2_key_data    = stb ? d : 8'($urandom);
      key_ack         = ack;
      model_step(stb, d, ack);
   endtask

   task automatic do_reset();
      @(posedge clock);
      #3;
      resetn          = 1'b0;
      ps2_key_pressed = 1'b0;
      key_ack         = 1'b0;
      #1;
      chk("reset_outputs", {key_valid, key_code, key_release, key_extended, 3'(fifo_count), overflow},
          32'h0);
      exp_q.delete();
      m_count = 0;
      m_ovf   = 0;
      m_ext   = 0;
      m_brk   = 0;
      m_held  = 0;
      @(posedge clock);
      #3;
      resetn = 1'b1;
   endtask

   // Monitor: head must match the oldest expected event; consumed on ack
   initial begin
      forever begin
         @(negedge clock);
         if (resetn) begin
            if (key_valid) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_event", {22'h0, key_extended, key_release, key_code}, 32'h3ff);
               end else begin
                  chk("head_event", {22'h0, key_extended, key_release, key_code}, 32'(exp_q[0]));
                  if (key_ack) void'(exp_q.pop_front());
               end
            end else begin
               chk("empty_outputs", {key_code, key_release, key_extended}, 32'h0);
            end
         end
      end
   end

   initial begin
      #2;
      chk("reset_state", {key_valid, key_code, key_release, key_extended, 3'(fifo_count), overflow},
          32'h0);
      @(posedge clock);
      #3;
      resetn = 1'b1;

      drive(1, 8'h1C, 0);
      drive(0, 8'h00, 0);
      chk("make_1c_code", 32'(key_code), 32'h1C);
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);

      drive(1, 8'hE0, 0);
      drive(1, 8'hF0, 0);
      drive(1, 8'h75, 0);
      drive(0, 8'h00, 0);
      chk("ext_break_flags", {key_extended, key_release, key_code}, 32'h375);
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);

      do_reset();
      for (int i = 0; i < 5; i++) drive(1, 8'(8'h15 + i), 0);
      drive(0, 8'h00, 0);
      chk("full_count", 32'(fifo_count), 32'd4);
      chk("full_overflow", 32'(overflow), 32'd1);
      drive(1, 8'h22, 1);
      drive(0, 8'h00, 0);
      chk("push_pop_full", 32'(fifo_count), 32'd4);
      for (int i = 0; i < 4; i++) drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);

      drive(1, 8'hF0, 0);
      do_reset();
      drive(1, 8'h1C, 0);
      drive(0, 8'h00, 0);
      chk("post_reset_make", {key_extended, key_release, key_code}, 32'h01C);
      drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);

      do_reset();
      drive(1, 8'h1C, 0);
      drive(1, 8'h1C, 0);
      drive(1, 8'h1C, 0);
      drive(1, 8'hF0, 0);
      drive(1, 8'h1C, 0);
      drive(0, 8'h00, 0);
      chk("typematic_events", 32'(fifo_count), 32'(TYPEMATIC_EVENTS));
      for (int i = 0; i < 5; i++) drive(0, 8'h00, 1);

      do_reset();
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 2) != 0), pool[$urandom_range(0, 15)],
               1'($urandom_range(0, 2) == 0));
      end
      for (int i = 0; i < 20 && m_count > 0; i++) drive(0, 8'h00, 1);
      drive(0, 8'h00, 0);
      drive(0, 8'h00, 0);
      chk("drain_count", 32'(m_count), 32'd0);
      chk("drain_scoreboard", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, event FIFO depth in entries (power of 2, 2..16).
REQ-002 SHALL have parameter CW, default 3, width of fifo_count (log2(DEPTH)+1).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ps2_key_pressed  input  1  one-cycle strobe per received PS/2 byte.
REQ-006 SHALL have port ps2_key_data  input  8  received scan-code byte (set 2), valid with strobe.
REQ-007 SHALL have port key_ack  input  1  consumer pops head event when key_valid is high.
REQ-008 SHALL have port key_valid  output  1  FIFO non-empty; head event presented.
REQ-009 SHALL have port key_code  output  8  head event final scan code.
REQ-010 SHALL have port key_release  output  1  head event is a break (key up).
REQ-011 SHALL have port key_extended  output  1  head event was E0-prefixed.
REQ-012 SHALL have port fifo_count  output  CW  number of queued events.
REQ-013 SHALL have port overflow  output  1  sticky flag: an event was dropped on full.

Function
REQ-014 SHALL run a prefix FSM with states IDLE, EXT, BRK, EXT_BRK, updated only on strobe cycles.
REQ-015 SHALL on byte 0xE0 enter EXT from any state (restart sequence).
REQ-016 SHALL on byte 0xF0 go IDLE->BRK, EXT->EXT_BRK; in BRK/EXT_BRK stay unchanged.
REQ-017 SHALL discard bytes 0xAA, 0xEE, 0xFA, 0xFE, 0x00, 0xFF with no state change and no event.
REQ-018 SHALL on any other byte form event {extended=(EXT|EXT_BRK), release=(BRK|EXT_BRK), code=byte} and return to IDLE.
REQ-019 SHALL push an event in the cycle after its completing strobe; key_valid rises one cycle after that strobe when FIFO was empty.
REQ-020 SHALL present head entry combinationally from FIFO storage; outputs stable while key_valid high and no pop.
REQ-021 SHALL pop on a cycle where key_ack && key_valid; key_ack with FIFO empty is ignored.
REQ-022 SHALL on push when full and no pop in same cycle drop the new event and set overflow; FIFO contents unchanged.
REQ-023 SHALL on simultaneous push and pop (including when full) perform both; fifo_count unchanged.
REQ-024 SHALL wrap read/write pointers modulo DEPTH; fifo_count ranges 0..DEPTH exactly.
REQ-025 SHALL clear overflow only by reset.
REQ-026 SHALL ignore ps2_key_data when ps2_key_pressed is low.

Reset
REQ-027 SHALL on resetn low asynchronously force FSM to IDLE, pointers and fifo_count to 0, overflow 0, key_valid 0.
REQ-028 SHALL drive key_code 0x00, key_release 0, key_extended 0 while FIFO empty and during reset.
REQ-029 SHALL discard any partial prefix sequence and queued events on reset mid-operation; first post-reset strobe processed from IDLE.

Configuration
REQ-030 SHALL, when PS2_TYPEMATIC_FILTER_EN is defined, record {extended,code} of last pushed make event plus a held flag.
REQ-031 SHALL, with PS2_TYPEMATIC_FILTER_EN defined, drop a make event equal to the held key while held is set (no push, no overflow).
REQ-032 SHALL, with PS2_TYPEMATIC_FILTER_EN defined, clear held on a break event of the held key; other breaks leave held unchanged; reset clears held.
REQ-033 SHALL, without PS2_TYPEMATIC_FILTER_EN, push every make event including typematic repeats.

Verification
REQ-034 SHALL cover: strobe 0x1C -> next cycle key_valid=1, key_code=0x1C, release=0, extended=0, fifo_count=1.
REQ-035 SHALL cover: strobes E0,F0,75 -> one event code=0x75, release=1, extended=1; no events for prefix bytes.
REQ-036 SHALL cover: 5 make codes 0x15..0x19, no ack, DEPTH=4 -> fifo_count=4, overflow=1, head 0x15, 0x19 lost.
REQ-037 SHALL cover: FIFO full, key_ack high in same cycle as completing strobe 0x22 -> fifo_count stays 4, 0x22 at tail.
REQ-038 SHALL cover: strobes F0 then resetn pulse low then 0x1C -> single make event 0x1C, release=0.
REQ-039 SHALL cover: filter on, strobes 1C,1C,1C,F0,1C -> exactly two events (make 1C, break 1C); filter off -> four events.
